pulse_gen_multi: RTL and testbench
==================================

Name: pulse_gen_multi

Overview:
- Multi-channel, runtime-programmable successor to the single-channel fixed-width pulse generator.
- Each channel turns a one-cycle trigger into a pulse with programmable delay and width, both at bit (sub-clock) resolution.
- Output is a DATA_WIDTH-bit parallel word per channel per clock, feeding a downstream serializer; bit 0 is earliest in time.
- Adds per-channel retrigger mode and a busy flag, which the fixed-width generator lacks.

Parameters:
- NUM_CH, 4, number of independent channels.
- DATA_WIDTH, 64, bits per output word per channel (serializer ratio).
- DLY_WIDTH, 16, width of the delay field, in bit units.
- WID_WIDTH, 16, width of the pulse-width field, in bit units.

Ports:
- clk  in  1  core clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_trig  in  NUM_CH  per-channel trigger; every cycle it is high is a trigger event.
- i_delay  in  NUM_CH*DLY_WIDTH  per-channel delay in bits; channel c at [c*DLY_WIDTH +: DLY_WIDTH].
- i_width  in  NUM_CH*WID_WIDTH  per-channel pulse width in bits; same packing.
- i_mode  in  NUM_CH  per channel: 0 = ignore triggers while busy, 1 = restart on trigger.
- o_pulse  out  NUM_CH*DATA_WIDTH  per-channel output word; channel c at [c*DATA_WIDTH +: DATA_WIDTH].
- o_busy  out  NUM_CH  high in every cycle the channel's current output word contains pulse bits or pending delay.

Behaviour:
- Reset: async assert clears all state. o_pulse=0, o_busy=0. Channels return to IDLE immediately, including mid-pulse; no partial word is emitted after rst.
- Per-channel registers:
  - S: start offset, DLY_WIDTH+1 bits.
  - E: end offset, max(DLY_WIDTH,WID_WIDTH)+2 bits.
  - State: IDLE or RUN.
- Acceptance at edge with i_trig[c]=1:
  - Always accepted when the channel is in IDLE.
  - Always accepted when the current word is the channel's final word (E <= DATA_WIDTH).
  - In RUN otherwise: mode 0 ignores the trigger; mode 1 accepts it and aborts the old pulse.
  - Accepting loads S=i_delay, E=i_delay+i_width, sampled in the trigger cycle only.
- Width zero: trigger accepted but produces no output. Channel stays or goes to IDLE with o_busy=0; mode 0 also treats it as idle.
- Latency: trigger at edge N puts the first candidate word on o_pulse after edge N+1. Time origin is bit 0 of that word.
- Word generation in RUN, registered: bit k = (k >= S) && (k < E), for k = 0..DATA_WIDTH-1.
- After each word: S = sat0(S-DATA_WIDTH), E = sat0(E-DATA_WIDTH).
- Leaving RUN: after emitting a word with E <= DATA_WIDTH, go to IDLE unless a trigger was accepted that cycle. Next word is 0.
- o_busy is registered alongside o_pulse. It is 1 for every word emitted in RUN, including all-zero delay words.
- Restart (mode 1): the word after the accepting edge follows the new S/E only. Old pulse bits are dropped with no OR-merge.
- Pulse may span any number of words. Total asserted bits equal i_width exactly; no gaps between words.
- Channels are fully independent. Simultaneous triggers on all channels are legal.
- Delay/width inputs may change freely while not triggering.

Test Plan:
- Basic (NUM_CH=2, DATA_WIDTH=64), trig ch0 D=0 W=64 at edge N -> o_pulse[63:0]=all ones after edge N+1 only; o_busy[0] high exactly 1 cycle; ch1 stays 0.
- Spanning, D=10 W=100 -> word1 = bits 10..63 set (54 bits), word2 = bits 0..45 set (46 bits), then 0. busy 2 cycles.
- Long delay, D=200 W=8 -> words 1-3 zero with busy=1; word4 = bits 8..15 set; busy 4 cycles.
- Mode 0 vs mode 1, D=0 W=256, second trigger (D=0 W=32) at the 2nd word:
  - mode 0 -> 4 full words, second trigger ignored.
  - mode 1 -> 2 full words, then a word with bits 0..31 set, then idle.
- Back-to-back and reset:
  - Trigger in the final-word cycle (mode 0) -> accepted, no idle gap.
  - W=0 -> no output, busy stays 0.
  - rst asserted mid-pulse -> o_pulse and o_busy go to 0 asynchronously.
  - After reset release, a fresh trigger behaves as in the basic scenario.

Source files
------------

// File: rtl/pulse_gen_multi.sv
// Multi-channel pulse generator: each trigger becomes a pulse with programmable delay and width
// (bit resolution), emitted as DATA_WIDTH-bit parallel words (bit 0 earliest) for a serializer.
module pulse_gen_multi #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 64,
  parameter int DLY_WIDTH  = 16,
  parameter int WID_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CH-1:0]                i_trig,
  input  logic [NUM_CH*DLY_WIDTH-1:0]      i_delay,
  input  logic [NUM_CH*WID_WIDTH-1:0]      i_width,
  input  logic [NUM_CH-1:0]                i_mode,
  output logic [NUM_CH*DATA_WIDTH-1:0]     o_pulse,
  output logic [NUM_CH-1:0]                o_busy
);

  localparam int SW = DLY_WIDTH + 1;
  localparam int MW = (DLY_WIDTH > WID_WIDTH) ? DLY_WIDTH : WID_WIDTH;
  localparam int EW = MW + 2;

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    state_t                  r_state, w_state_next;
    logic [SW-1:0]           r_s, w_s_next;
    logic [EW-1:0]           r_e, w_e_next;
    logic [DATA_WIDTH-1:0]   r_word, w_word_next;
    logic                    r_busy, w_busy_next;
    logic [DLY_WIDTH-1:0]    w_dly;
    logic [WID_WIDTH-1:0]    w_wid;
    logic [31:0]             w_s32, w_e32;
    logic                    w_final, w_accept;

    assign w_dly = i_delay[gi*DLY_WIDTH +: DLY_WIDTH];
    assign w_wid = i_width[gi*WID_WIDTH +: WID_WIDTH];
    assign w_s32 = 32'(r_s);
    assign w_e32 = 32'(r_e);

    // The word being generated now is the last one of the pulse.
    assign w_final  = (w_e32 <= 32'(DATA_WIDTH));
    assign w_accept = i_trig[gi] && ((r_state == ST_IDLE) || w_final || i_mode[gi]);

    always_comb begin
      w_state_next = r_state;
      w_s_next     = r_s;
      w_e_next     = r_e;
      w_word_next  = '0;
      w_busy_next  = 1'b0;
      if (r_state == ST_RUN) begin
        w_busy_next = 1'b1;
        for (int k = 0; k < DATA_WIDTH; k++) begin
          w_word_next[k] = (w_s32 <= 32'(k)) && (32'(k) < w_e32);
        end
        w_s_next = (w_s32 > 32'(DATA_WIDTH)) ? SW'(w_s32 - 32'(DATA_WIDTH)) : '0;
        w_e_next = (w_e32 > 32'(DATA_WIDTH)) ? EW'(w_e32 - 32'(DATA_WIDTH)) : '0;
        if (w_final) begin
          w_state_next = ST_IDLE;
        end
      end
      // An accepted trigger replaces the offsets outright, so old bits are never merged in.
      if (w_accept) begin
        w_s_next     = SW'(w_dly);
        w_e_next     = EW'(w_dly) + EW'(w_wid);
        w_state_next = (w_wid == '0) ? ST_IDLE : ST_RUN;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state <= ST_IDLE;
        r_s     <= '0;
        r_e     <= '0;
        r_word  <= '0;
        r_busy  <= 1'b0;
      end else begin
        r_state <= w_state_next;
        r_s     <= w_s_next;
        r_e     <= w_e_next;
        r_word  <= w_word_next;
        r_busy  <= w_busy_next;
      end
    end

    assign o_pulse[gi*DATA_WIDTH +: DATA_WIDTH] = r_word;
    assign o_busy[gi]                           = r_busy;
  end

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Bench for pulse_gen_multi: absolute-timeline model checked every cycle, plus literal word checks.
module tb_pulse_gen_multi;
  localparam int NCH = 2;
  localparam int DW  = 64;
  localparam int DLW = 16;
  localparam int WDW = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NCH-1:0]       i_trig = '0;
  logic [NCH*DLW-1:0]   i_delay = '0;
  logic [NCH*WDW-1:0]   i_width = '0;
  logic [NCH-1:0]       i_mode = '0;
  logic [NCH*DW-1:0]    o_pulse;
  logic [NCH-1:0]       o_busy;

  int n_cmp = 0;
  int n_bad = 0;

  pulse_gen_multi #(.NUM_CH(NCH), .DATA_WIDTH(DW), .DLY_WIDTH(DLW), .WID_WIDTH(WDW)) dut (
    .clk(clk), .rst(rst), .i_trig(i_trig), .i_delay(i_delay), .i_width(i_width),
    .i_mode(i_mode), .o_pulse(o_pulse), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Model: each accepted pulse occupies absolute bit positions [m_s, m_e) on a timeline where
  // word n covers bits n*DW .. n*DW+DW-1; the channel is busy up to word m_last.
  initial begin : model_cmp
    longint n;
    bit     m_act [NCH];
    longint m_s   [NCH];
    longint m_e   [NCH];
    longint m_last[NCH];
    logic [DW-1:0] exp_word[NCH];
    bit     exp_busy[NCH];
    logic [NCH-1:0] s_trig, s_mode;
    logic [NCH*DLW-1:0] s_dly;
    logic [NCH*WDW-1:0] s_wid;
    logic s_rst;
    n = 0;
    for (int c = 0; c < NCH; c++) begin
      m_act[c] = 0; m_s[c] = 0; m_e[c] = 0; m_last[c] = 0;
    end
    forever begin
      @(posedge clk);
      s_trig = i_trig; s_mode = i_mode; s_dly = i_delay; s_wid = i_width; s_rst = rst;
      for (int c = 0; c < NCH; c++) begin
        bit run, acc;
        longint d, w, pos;
        if (s_rst) begin
          m_act[c] = 0;
          exp_word[c] = '0;
          exp_busy[c] = 0;
        end else begin
          run = m_act[c] && (n <= m_last[c]);
          for (int k = 0; k < DW; k++) begin
            pos = n * DW + k;
            exp_word[c][k] = run && (pos >= m_s[c]) && (pos < m_e[c]);
          end
          exp_busy[c] = run;
          acc = s_trig[c] && (!run || n == m_last[c] || s_mode[c]);
          d = longint'(s_dly[c*DLW +: DLW]);
          w = longint'(s_wid[c*WDW +: WDW]);
          if (acc) begin
            if (w == 0) begin
              m_act[c] = 0;
            end else begin
              m_act[c]  = 1;
              m_s[c]    = (n + 1) * DW + d;
              m_e[c]    = m_s[c] + w;
              m_last[c] = n + (d + w + DW - 1) / DW;
            end
          end else if (run && n == m_last[c]) begin
            m_act[c] = 0;
          end
        end
      end
      n++;
      #1;
      for (int c = 0; c < NCH; c++) begin
        chk($sformatf("model word ch%0d cyc%0d", c, n), o_pulse[c*DW +: DW], exp_word[c]);
        chk($sformatf("model busy ch%0d cyc%0d", c, n), 64'(o_busy[c]), 64'(exp_busy[c]));
      end
    end
  end

  task automatic do_trig(input int ch, input int d, input int w, input bit m);
    @(negedge clk);
    i_trig[ch] = 1'b1;
    i_delay[ch*DLW +: DLW] = DLW'(d);
    i_width[ch*WDW +: WDW] = WDW'(w);
    i_mode[ch] = m;
    $display("trig ch%0d delay=%0d width=%0d mode=%0d", ch, d, w, m);
    @(negedge clk);
    i_trig[ch] = 1'b0;
  endtask

  task automatic word_chk(input string nm, input logic [63:0] w0, input logic [1:0] busy);
    @(posedge clk);
    #2;
    chk({nm, " ch0 word"}, o_pulse[0 +: DW], w0);
    chk({nm, " busy"}, 64'(o_busy), 64'(busy));
  endtask

  task automatic basic(input string nm);
    do_trig(0, 0, 64, 1'b0);
    word_chk(nm, 64'hFFFF_FFFF_FFFF_FFFF, 2'b01);
    chk({nm, " ch1 word"}, o_pulse[DW +: DW], 64'h0);
    word_chk(nm, 64'h0, 2'b00);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("reset word", o_pulse[63:0], 64'h0);
    chk("reset busy", 64'(o_busy), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    basic("basic");

    do_trig(0, 10, 100, 1'b0);
    word_chk("span w1", 64'hFFFF_FFFF_FFFF_FC00, 2'b01);
    word_chk("span w2", 64'h0000_3FFF_FFFF_FFFF, 2'b01);
    word_chk("span end", 64'h0, 2'b00);

    do_trig(0, 200, 8, 1'b0);
    word_chk("long w1", 64'h0, 2'b01);
    word_chk("long w2", 64'h0, 2'b01);
    word_chk("long w3", 64'h0, 2'b01);
    word_chk("long w4", 64'h0000_0000_0000_FF00, 2'b01);
    word_chk("long end", 64'h0, 2'b00);

    do_trig(0, 0, 256, 1'b0);
    do_trig(0, 0, 32, 1'b0);
    word_chk("mode0 w3", 64'hFFFF_FFFF_FFFF_FFFF, 2'b01);
    word_chk("mode0 w4", 64'hFFFF_FFFF_FFFF_FFFF, 2'b01);
    word_chk("mode0 end", 64'h0, 2'b00);
    repeat (2) @(negedge clk);

    do_trig(0, 0, 256, 1'b1);
    do_trig(0, 0, 32, 1'b1);
    word_chk("mode1 w3", 64'h0000_0000_FFFF_FFFF, 2'b01);
    word_chk("mode1 end", 64'h0, 2'b00);
    repeat (2) @(negedge clk);

    do_trig(0, 0, 64, 1'b0);
    do_trig(0, 0, 64, 1'b0);
    word_chk("b2b w2", 64'hFFFF_FFFF_FFFF_FFFF, 2'b01);
    word_chk("b2b end", 64'h0, 2'b00);

    do_trig(0, 5, 0, 1'b0);
    word_chk("w0 c1", 64'h0, 2'b00);
    word_chk("w0 c2", 64'h0, 2'b00);

    // Both channels triggered in the same cycle.
    @(negedge clk);
    i_trig = 2'b11;
    i_delay = {16'd60, 16'd3};
    i_width = {16'd10, 16'd4};
    i_mode = 2'b10;
    $display("trig ch0 delay=3 width=4 + ch1 delay=60 width=10 simultaneous");
    @(negedge clk);
    i_trig = 2'b00;
    word_chk("dual w1", 64'h0000_0000_0000_0078, 2'b11);
    chk("dual ch1 w1", o_pulse[DW +: DW], 64'hF000_0000_0000_0000);
    word_chk("dual w2", 64'h0, 2'b10);
    chk("dual ch1 w2", o_pulse[DW +: DW], 64'h0000_0000_0000_003F);
    word_chk("dual end", 64'h0, 2'b00);

    do_trig(0, 0, 640, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    chk("pre-rst busy", 64'(o_busy), 64'h1);
    rst = 1'b1;
    $display("async reset mid-pulse");
    #1;
    chk("rst async word", o_pulse[63:0], 64'h0);
    chk("rst async busy", 64'(o_busy), 64'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    basic("post-rst");
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
